cache_wr_buffer: RTL and testbench
==================================

Name: cache_wr_buffer

Overview:
- Write buffer directly downstream of cache_4way_64KB.
- Accepts the cache's write-through stores and dirty evictions (word granularity) and drains them in order to the main-memory write port with a req/ack handshake.
- Provides a same-cycle lookup so cache read-miss fills forward buffered data instead of reading stale memory.
- Merges repeated writes to the same word address.

Parameters:
DEPTH, 4, number of entries (power of two, >=2)
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
iPush  in  1  cache presents a store this cycle
iPushAddr  in  AW  store word address
iPushData  in  DW  store data
oFull  out  1  no free entry; cache must hold iPush until a cycle it is accepted
iLkAddr  in  AW  read-miss lookup address
oLkHit  out  1  buffer holds a pending write to iLkAddr (combinational)
oLkData  out  DW  data of youngest matching entry (combinational; 0 when !oLkHit)
oMemWr  out  1  write request to memory
oMemAddr  out  AW  request address
oMemData  out  DW  request data
iMemAck  in  1  memory accepted the current request
oEmpty  out  1  no valid entries
oCount  out  clog2(DEPTH)+1  valid entry count

Behaviour:
- Reset (resetn low, asynchronous): all entries invalid, head/tail pointers 0, drain FSM to IDLE. Outputs: oFull=0, oEmpty=1, oCount=0, oMemWr=0, oMemAddr=0, oMemData=0, oLkHit=0, oLkData=0. Reset mid-transaction abandons the in-flight write; no recovery.
- Storage: circular FIFO, DEPTH entries of {valid, addr, data}. Tail pointer for allocation, head for drain. Pointers wrap modulo DEPTH.
- Push acceptance, evaluated each cycle with iPush=1:
  - Coalesce: a valid entry with addr==iPushAddr exists and is not the in-flight head (FSM in REQ and entry==head). Overwrite its data. Count unchanged. Permitted even when oFull=1.
  - Allocate: otherwise, and oFull=0. Write at tail, tail+1, count+1.
  - Drop: otherwise (full, no coalesce target). Store ignored; cache must retry.
- A push whose address matches only the in-flight head allocates a new entry, so ordering is preserved.
- oFull = (count==DEPTH), registered from the current count. It does not anticipate a same-cycle pop. Push and pop in the same cycle while not full: count unchanged.
- Drain FSM:
  - IDLE: if count>0, load oMemAddr/oMemData from head, set oMemWr=1, go to REQ (1 cycle after entry becomes valid).
  - REQ: hold oMemWr/oMemAddr/oMemData stable until iMemAck=1. On ack: invalidate head, head+1, count-1. If count after pop >0, remain in REQ and present the next head the following cycle (back-to-back, one write per cycle with ack held high). Otherwise go to IDLE with oMemWr=0.
  - iMemAck while in IDLE is ignored.
- The head entry's data is frozen once it is presented (coalescing into it is blocked), so memory sees a stable request.
- Lookup: combinational compare of iLkAddr against all valid entries, including the in-flight head. The youngest match (closest to tail) wins. Coalescing guarantees at most two matches (the head plus one younger entry).
- A push in cycle N is visible to lookup from cycle N+1.
- oEmpty = (count==0). oCount is registered.

Test Plan:
- Single store: push FDEF_1000/1234_5678 in cycle 0, ack held high. Expect oMemWr=1 in cycle 1 with addr FDEF_1000, data 1234_5678; ack in cycle 1 leaves oEmpty=1 in cycle 2.
- Coalesce: iMemAck=0 throughout; push A=0000_0100/1111_1111, then B=0000_0200/2222_2222, then A/3333_3333. Expect oCount=2. Lookup A gives hit with 3333_3333 if A was not the in-flight head. Since A is the head in REQ, expect instead count=3, and lookup A returns 3333_3333 (youngest).
- Full/drop: ack=0; push 4 distinct addresses 0x10/0x20/0x30/0x40 (data 1..4). Expect oFull=1, oCount=4. Push 0x50/5 is dropped (count stays 4). Push 0x30/9 coalesces. Release ack: memory sees 0x10:1, 0x20:2, 0x30:9, 0x40:4 in order on 4 consecutive cycles.
- Handshake hold: ack withheld 7 cycles. oMemWr/addr/data remain stable for every cycle until ack, and only one write completes.
- Lookup miss/forward: lookup 0xFDEF_2000 on empty buffer gives oLkHit=0, oLkData=0. After a push to that address, the next cycle gives oLkHit=1 with the pushed data.
- Reset mid-drain: assert resetn=0 while oMemWr=1 with 3 entries. Outputs return to reset values immediately (asynchronously). After release, oEmpty=1 and no memory request is issued.

Source files
------------

// File: rtl/cache_wr_buffer.sv
// Word-granular write buffer between the cache and the memory write port.
// In-order drain with req/ack, same-address coalescing and combinational lookup.
module cache_wr_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     iPush,
    input  logic [AW-1:0]            iPushAddr,
    input  logic [DW-1:0]            iPushData,
    output logic                     oFull,
    input  logic [AW-1:0]            iLkAddr,
    output logic                     oLkHit,
    output logic [DW-1:0]            oLkData,
    output logic                     oMemWr,
    output logic [AW-1:0]            oMemAddr,
    output logic [DW-1:0]            oMemData,
    input  logic                     iMemAck,
    output logic                     oEmpty,
    output logic [$clog2(DEPTH):0]   oCount
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t          state_q, state_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]   addr_q [DEPTH];
    logic [AW-1:0]   addr_d [DEPTH];
    logic [DW-1:0]   data_q [DEPTH];
    logic [DW-1:0]   data_d [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   memAddr_q, memAddr_d;
    logic [DW-1:0]   memData_q, memData_d;

    logic            coalHit;
    logic [PW-1:0]   coalIdx;
    logic            pop, doCoal, doAlloc, loadHead;

    assign oFull  = (count_q == CW'(DEPTH));
    assign oEmpty = (count_q == '0);
    assign oCount = count_q;

    // Entries are scanned oldest to youngest so the last match found is the youngest.
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        oLkHit  = 1'b0;
        oLkData = '0;
        coalHit = 1'b0;
        coalIdx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && addr_q[idx] == iLkAddr) begin
                oLkHit  = 1'b1;
                oLkData = data_q[idx];
            end
            if (valid_q[idx] && addr_q[idx] == iPushAddr &&
                !(state_q == REQ && idx == head_q)) begin
                coalHit = 1'b1;
                coalIdx = idx;
            end
        end
    end

    always_comb begin
        pop     = (state_q == REQ) && iMemAck;
        doCoal  = iPush && coalHit;
        doAlloc = iPush && !coalHit && !oFull;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (pop)
            valid_d[head_q] = 1'b0;
        if (doCoal)
            data_d[coalIdx] = iPushData;
        if (doAlloc) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = iPushAddr;
            data_d[tail_q]  = iPushData;
        end
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(doAlloc);
        count_d = count_q + CW'(doAlloc) - CW'(pop);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_d != '0) state_d = REQ;
            REQ:     if (pop && count_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The request is captured from the post-update head, so a same-cycle push is seen.
    always_comb begin
        loadHead  = (state_d == REQ) && ((state_q == IDLE) || pop);
        memAddr_d = loadHead ? addr_d[head_d] : memAddr_q;
        memData_d = loadHead ? data_d[head_d] : memData_q;
    end

    always_comb begin
        oMemWr   = (state_q == REQ);
        oMemAddr = memAddr_q;
        oMemData = memData_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            memAddr_q <= '0;
            memData_q <= '0;
        end else begin
            valid_q   <= valid_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            memAddr_q <= memAddr_d;
            memData_q <= memData_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_cache_wr_buffer.sv
// Scoreboarded bench for cache_wr_buffer: expected memory writes are queued
// as stores are driven and checked as each acknowledged request leaves the DUT.
module tb_cache_wr_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          iPush;
    logic [AW-1:0] iPushAddr;
    logic [DW-1:0] iPushData;
    logic          oFull;
    logic [AW-1:0] iLkAddr;
    logic          oLkHit;
    logic [DW-1:0] oLkData;
    logic          oMemWr;
    logic [AW-1:0] oMemAddr;
    logic [DW-1:0] oMemData;
    logic          iMemAck;
    logic          oEmpty;
    logic [2:0]    oCount;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [63:0]   expQ [$];

    cache_wr_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .resetn(resetn),
        .iPush(iPush), .iPushAddr(iPushAddr), .iPushData(iPushData), .oFull(oFull),
        .iLkAddr(iLkAddr), .oLkHit(oLkHit), .oLkData(oLkData),
        .oMemWr(oMemWr), .oMemAddr(oMemAddr), .oMemData(oMemData), .iMemAck(iMemAck),
        .oEmpty(oEmpty), .oCount(oCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [AW-1:0] a, input logic [DW-1:0] d);
        iPush     = 1'b1;
        iPushAddr = a;
        iPushData = d;
        tick();
        iPush     = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [AW-1:0] a,
                          input logic expHit, input logic [DW-1:0] expData);
        iLkAddr = a;
        #1;
        checkOutput({tag, "Hit"}, 64'(oLkHit), 64'(expHit));
        checkOutput({tag, "Data"}, 64'(oLkData), 64'(expData));
    endtask

    // Any acknowledged request must be the oldest outstanding expected write.
    always @(negedge clk) begin
        if (resetn === 1'b1 && oMemWr === 1'b1 && iMemAck === 1'b1) begin
            checkOutput("writeExpected", 64'(expQ.size() != 0), 64'd1);
            if (expQ.size() != 0)
                checkOutput("memWrite", {oMemAddr, oMemData}, expQ.pop_front());
        end
    end

    initial begin
        resetn    = 1'b0;
        iPush     = 1'b0;
        iPushAddr = '0;
        iPushData = '0;
        iLkAddr   = '0;
        iMemAck   = 1'b0;
        repeat (2) tick();
        checkOutput("rstFull",    64'(oFull),    64'd0);
        checkOutput("rstEmpty",   64'(oEmpty),   64'd1);
        checkOutput("rstCount",   64'(oCount),   64'd0);
        checkOutput("rstMemWr",   64'(oMemWr),   64'd0);
        checkOutput("rstMemReq",  {oMemAddr, oMemData}, 64'd0);
        lookup("rstLk", 32'h0, 1'b0, 32'h0);
        resetn = 1'b1;
        tick();

        // Single store with ack held high.
        iMemAck = 1'b1;
        expQ.push_back({32'hFDEF_1000, 32'h1234_5678});
        applyStimulus(32'hFDEF_1000, 32'h1234_5678);
        checkOutput("singleMemWr",  64'(oMemWr), 64'd1);
        checkOutput("singleReq",    {oMemAddr, oMemData}, {32'hFDEF_1000, 32'h1234_5678});
        tick();
        checkOutput("singleEmpty",  64'(oEmpty), 64'd1);
        checkOutput("singleIdle",   64'(oMemWr), 64'd0);
        iMemAck = 1'b0;

        // Lookup miss, then forwarding one cycle after the push.
        lookup("lkMiss", 32'hFDEF_2000, 1'b0, 32'h0);
        iPush     = 1'b1;
        iPushAddr = 32'hFDEF_2000;
        iPushData = 32'hCAFE_BABE;
        expQ.push_back({32'hFDEF_2000, 32'hCAFE_BABE});
        #1;
        checkOutput("lkSameCycle", 64'(oLkHit), 64'd0);
        tick();
        iPush = 1'b0;
        lookup("lkFwd", 32'hFDEF_2000, 1'b1, 32'hCAFE_BABE);
        iMemAck = 1'b1;
        tick();
        iMemAck = 1'b0;
        checkOutput("lkDrained", 64'(oEmpty), 64'd1);

        // Same address as in-flight head allocates; youngest wins on lookup.
        expQ.push_back({32'h0000_0100, 32'h1111_1111});
        expQ.push_back({32'h0000_0200, 32'h2222_2222});
        expQ.push_back({32'h0000_0100, 32'h3333_3333});
        applyStimulus(32'h0000_0100, 32'h1111_1111);
        applyStimulus(32'h0000_0200, 32'h2222_2222);
        applyStimulus(32'h0000_0100, 32'h3333_3333);
        checkOutput("headCoalCount", 64'(oCount), 64'd3);
        checkOutput("headFrozen", 64'(oMemData), 64'h1111_1111);
        lookup("youngA", 32'h0000_0100, 1'b1, 32'h3333_3333);
        lookup("youngB", 32'h0000_0200, 1'b1, 32'h2222_2222);
        iMemAck = 1'b1;
        repeat (3) tick();
        iMemAck = 1'b0;
        checkOutput("headCoalEmpty", 64'(oEmpty), 64'd1);

        // Coalescing into a younger, non-head entry.
        expQ.push_back({32'h0000_0C00, 32'h0000_0001});
        expQ.push_back({32'h0000_0D00, 32'h0000_0005});
        applyStimulus(32'h0000_0C00, 32'h0000_0001);
        applyStimulus(32'h0000_0D00, 32'h0000_0002);
        applyStimulus(32'h0000_0D00, 32'h0000_0005);
        checkOutput("coalCount", 64'(oCount), 64'd2);
        lookup("coalD", 32'h0000_0D00, 1'b1, 32'h0000_0005);
        iMemAck = 1'b1;
        repeat (2) tick();
        iMemAck = 1'b0;

        // Full, drop, coalesce while full, then back-to-back drain.
        for (int i = 1; i <= 4; i++)
            applyStimulus(32'(i * 16), 32'(i));
        checkOutput("fullFlag",  64'(oFull),  64'd1);
        checkOutput("fullCount", 64'(oCount), 64'd4);
        applyStimulus(32'h50, 32'h5);
        checkOutput("dropCount", 64'(oCount), 64'd4);
        lookup("dropLk", 32'h50, 1'b0, 32'h0);
        applyStimulus(32'h30, 32'h9);
        checkOutput("fullCoalCount", 64'(oCount), 64'd4);
        lookup("fullCoalLk", 32'h30, 1'b1, 32'h9);
        expQ.push_back({32'h10, 32'h1});
        expQ.push_back({32'h20, 32'h2});
        expQ.push_back({32'h30, 32'h9});
        expQ.push_back({32'h40, 32'h4});
        iMemAck = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("b2bMemWr", 64'(oMemWr), 64'd1);
            tick();
        end
        iMemAck = 1'b0;
        checkOutput("b2bEmpty", 64'(oEmpty), 64'd1);
        checkOutput("b2bIdle",  64'(oMemWr), 64'd0);

        // Request held stable while ack is withheld.
        expQ.push_back({32'h0000_0077, 32'h0000_ABCD});
        applyStimulus(32'h0000_0077, 32'h0000_ABCD);
        for (int i = 0; i < 7; i++) begin
            checkOutput("holdMemWr", 64'(oMemWr), 64'd1);
            checkOutput("holdReq", {oMemAddr, oMemData}, {32'h0000_0077, 32'h0000_ABCD});
            tick();
        end
        iMemAck = 1'b1;
        tick();
        iMemAck = 1'b0;
        checkOutput("holdOneWrite", 64'(oEmpty), 64'd1);
        checkOutput("holdIdle", 64'(oMemWr), 64'd0);

        // Asynchronous reset in the middle of a drain abandons everything.
        applyStimulus(32'h100, 32'hA);
        applyStimulus(32'h200, 32'hB);
        applyStimulus(32'h300, 32'hC);
        checkOutput("preRstCount", 64'(oCount), 64'd3);
        checkOutput("preRstMemWr", 64'(oMemWr), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("asyncMemWr",  64'(oMemWr), 64'd0);
        checkOutput("asyncEmpty",  64'(oEmpty), 64'd1);
        checkOutput("asyncCount",  64'(oCount), 64'd0);
        checkOutput("asyncReq",    {oMemAddr, oMemData}, 64'd0);
        lookup("asyncLk", 32'h200, 1'b0, 32'h0);
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("postRstMemWr", 64'(oMemWr), 64'd0);
            checkOutput("postRstEmpty", 64'(oEmpty), 64'd1);
        end

        checkOutput("scoreboardDrained", 64'(expQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
